pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 28 ++
 rtl/pipe_stage_reg.sv | 127 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// The master modport is the surrounding pipeline; the slave modport is the stage itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RD_W-1:0]   in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [RD_W-1:0]   out_rd;

  modport master (
    output in_valid, in_data, in_ctrl, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_rd
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_rd
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register: HEAD drives the downstream stage, SKID absorbs one
// extra instruction so in_ready never depends combinationally on out_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int RD_W   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_stage_reg_if.slave      bus,
  output logic [1:0]           level
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid/data are held until the transfer, ready never depends on the partner's valid.

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] head_data, skid_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic [RD_W-1:0]   head_rd,   skid_rd;

  logic accept, consume;
  logic load_head_in, load_skid_in, head_from_skid, clear_all;

  assign bus.in_ready  = reset & (state_q != S_FULL) & ~flush;
  assign bus.out_valid = (state_q != S_EMPTY) & ~flush;
  assign accept        = bus.in_valid & bus.in_ready;
  assign consume       = bus.out_valid & bus.out_ready;

  // Bubbles present all-zero payload so no stale reg_write/mem_write leaks downstream.
  assign bus.out_data = bus.out_valid ? head_data : '0;
  assign bus.out_ctrl = bus.out_valid ? head_ctrl : '0;
  assign bus.out_rd   = bus.out_valid ? head_rd   : '0;

  // The state register doubles as the occupancy count.
  assign level = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_skid_in   = 1'b0;
    head_from_skid = 1'b0;
    clear_all      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d      = S_ONE;
          load_head_in = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && consume) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          state_d      = S_FULL;
          load_skid_in = 1'b1;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (consume) begin
          state_d        = S_ONE;
          head_from_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d        = S_EMPTY;
      load_head_in   = 1'b0;
      load_skid_in   = 1'b0;
      head_from_skid = 1'b0;
      clear_all      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_data <= '0;
      head_ctrl <= '0;
      head_rd   <= '0;
    end else if (clear_all) begin
      head_data <= '0;
      head_ctrl <= '0;
      head_rd   <= '0;
    end else if (load_head_in) begin
      head_data <= bus.in_data;
      head_ctrl <= bus.in_ctrl;
      head_rd   <= bus.in_rd;
    end else if (head_from_skid) begin
      head_data <= skid_data;
      head_ctrl <= skid_ctrl;
      head_rd   <= skid_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_data <= '0;
      skid_ctrl <= '0;
      skid_rd   <= '0;
    end else if (clear_all) begin
      skid_data <= '0;
      skid_ctrl <= '0;
      skid_rd   <= '0;
    end else if (load_skid_in) begin
      skid_data <= bus.in_data;
      skid_ctrl <= bus.in_ctrl;
      skid_rd   <= bus.in_rd;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } entry_t;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [1:0] level;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) bus ();

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave),
    .level (level)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The stage is a FIFO of depth two: everything accepted leaves in order.
  entry_t exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      logic acc, con;
      entry_t e;
      acc = bus.in_valid && (exp_q.size() < 2);
      con = bus.out_ready && (exp_q.size() > 0);
      e.data = bus.in_data;
      e.ctrl = bus.in_ctrl;
      e.rd   = bus.in_rd;
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic   ev, er;
    entry_t h;
    ev = reset && !flush && (exp_q.size() > 0);
    er = reset && !flush && (exp_q.size() < 2);
    h  = ev ? exp_q[0] : '0;
    check("mdl_out_valid", 64'(bus.out_valid), 64'(ev));
    check("mdl_in_ready",  64'(bus.in_ready),  64'(er));
    check("mdl_out_data",  64'(bus.out_data),  64'(h.data));
    check("mdl_out_ctrl",  64'(bus.out_ctrl),  64'(h.ctrl));
    check("mdl_out_rd",    64'(bus.out_rd),    64'(h.rd));
    check("mdl_level",     64'(level),         64'(exp_q.size()));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.in_rd     = d[RD_W-1:0];
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    check("rst_level",     64'(level),         64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    repeat (2) step();
    reset = 1'b1;
    step();

    // Streaming at full rate
    drive(1'b1, 32'h10, 8'h01, 1'b1, 1'b0); step();
    check("stream_d0", 64'(bus.out_data), 64'h10);
    check("stream_l0", 64'(level), 64'd1);
    drive(1'b1, 32'h11, 8'h02, 1'b1, 1'b0); step();
    check("stream_d1", 64'(bus.out_data), 64'h11);
    check("stream_l1", 64'(level), 64'd1);
    drive(1'b1, 32'h12, 8'h03, 1'b1, 1'b0); step();
    check("stream_d2", 64'(bus.out_data), 64'h12);
    check("stream_l2", 64'(level), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    check("stream_drain", 64'(level), 64'd0);

    // Back-pressure fills the skid entry
    drive(1'b1, 32'hA1, 8'h11, 1'b0, 1'b0); step();
    check("bp_l1", 64'(level), 64'd1);
    drive(1'b1, 32'hA2, 8'h12, 1'b0, 1'b0); step();
    check("bp_l2",    64'(level), 64'd2);
    check("bp_ready", 64'(bus.in_ready), 64'd0);
    check("bp_hold",  64'(bus.out_data), 64'hA1);
    drive(1'b1, 32'hAF, 8'h1F, 1'b0, 1'b0); step();
    check("bp_stable", 64'(bus.out_data), 64'hA1);
    check("bp_ctrl",   64'(bus.out_ctrl), 64'h11);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    check("bp_first", 64'(bus.out_data), 64'hA1);
    step();
    check("bp_second", 64'(bus.out_data), 64'hA2);
    check("bp_l_one",  64'(level), 64'd1);
    step();
    check("bp_l_zero", 64'(level), 64'd0);
    check("bp_empty",  64'(bus.out_valid), 64'd0);

    // Flush while full, with a new instruction offered
    drive(1'b1, 32'hB1, 8'h21, 1'b0, 1'b0); step();
    drive(1'b1, 32'hB2, 8'h22, 1'b0, 1'b0); step();
    check("fl_full", 64'(level), 64'd2);
    drive(1'b1, 32'hB3, 8'h23, 1'b1, 1'b1);
    #1;
    check("fl_same_cyc_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("fl_level", 64'(level), 64'd0);
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_ctrl",  64'(bus.out_ctrl), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();
    check("fl_no_b3", 64'(bus.out_valid), 64'd0);

    // Simultaneous accept and consume in ONE
    drive(1'b1, 32'hC1, 8'h31, 1'b1, 1'b0); step();
    check("sim_head", 64'(bus.out_data), 64'hC1);
    drive(1'b1, 32'hC2, 8'h32, 1'b1, 1'b0); step();
    check("sim_data",  64'(bus.out_data), 64'hC2);
    check("sim_level", 64'(level), 64'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0); step();

    // Asynchronous reset while full
    drive(1'b1, 32'hD1, 8'h41, 1'b0, 1'b0); step();
    drive(1'b1, 32'hD2, 8'h42, 1'b0, 1'b0); step();
    check("ar_full", 64'(level), 64'd2);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_data",  64'(bus.out_data),  64'd0);
    check("ar_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("ar_level", 64'(level),         64'd0);
    check("ar_ready", 64'(bus.in_ready),  64'd0);
    step();
    #1;
    reset = 1'b1;
    drive(1'b1, 32'hD4, 8'h5A, 1'b1, 1'b0); step();
    check("ar_d4_data", 64'(bus.out_data), 64'hD4);
    check("ar_d4_ctrl", 64'(bus.out_ctrl), 64'h5A);
    check("ar_d4_rd",   64'(bus.out_rd),   64'h14);

    // Bubbles with noisy control inputs
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'hFFFF_FFFF, 8'hFF, 1'b1, 1'b0); step();
      check("bub_valid", 64'(bus.out_valid), 64'd0);
      check("bub_ctrl",  64'(bus.out_ctrl),  64'd0);
      check("bub_rd",    64'(bus.out_rd),    64'd0);
    end

    // Mixed traffic checked by the model only
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) + 32'h100,
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      step();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
